// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter sharing the 8-bit uio pad bus between NUM_REQ requesters,
// with an all-enables-low turnaround between owners. Optional forced revoke: UIO_ARB_TIMEOUT_EN.
module uio_bus_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int TURNAROUND = 1,
    parameter int MAX_HOLD   = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*8-1:0]       req_out_i,
    input  logic [NUM_REQ*8-1:0]       req_oe_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [NUM_REQ-1:0]         revoked_o,
    output logic [$clog2(NUM_REQ)-1:0] owner_o,
    output logic                       busy_o,
    output logic [7:0]                 uio_out_o,
    output logic [7:0]                 uio_oe_o
);
    // state | meaning
    // IDLE  | no owner; next edge with any req picks a winner after ptr_q
    // GRANT | owner_q drives the uio bus until it drops req (or is revoked)
    // TURN  | all enables low for TURNAROUND cycles; requests stay pending

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int TURN_W = $clog2(TURNAROUND + 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TURNAROUND < 1 || MAX_HOLD < 2) begin : g_param_chk
        $error("uio_bus_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t              state_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic [IDX_W-1:0]    owner_q;
    logic [IDX_W-1:0]    ptr_q;
    logic [TURN_W-1:0]   turn_q;
    logic                busy_q;

    logic [IDX_W-1:0]    sel_d;
    logic [NUM_REQ-1:0]  grant_d;
    logic                found_d;

    // Round-robin search starting one past the last winner, wrapping.
    always_comb begin
        sel_d   = ptr_q;
        found_d = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found_d && req_i[(int'(ptr_q) + k) % NUM_REQ]) begin
                found_d = 1'b1;
                sel_d   = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
        grant_d        = '0;
        grant_d[sel_d] = 1'b1;
    end

`ifdef UIO_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0]   hold_q;
    logic [NUM_REQ-1:0]  revoked_q;
    logic                others_d;

    assign others_d  = |(req_i & ~grant_q);
    assign revoked_o = revoked_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            revoked_q <= '0;
            owner_q   <= '0;
            ptr_q     <= IDX_W'(NUM_REQ - 1);
            turn_q    <= '0;
            busy_q    <= 1'b0;
            hold_q    <= '0;
        end else begin
            revoked_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (|req_i) begin
                        grant_q <= grant_d;
                        owner_q <= sel_d;
                        ptr_q   <= sel_d;
                        hold_q  <= HOLD_W'(1);
                        busy_q  <= 1'b1;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!req_i[owner_q]) begin
                        grant_q <= '0;
                        turn_q  <= TURN_W'(TURNAROUND);
                        state_q <= ST_TURN;
                    end else if (hold_q == HOLD_W'(MAX_HOLD) && others_d) begin
                        revoked_q <= grant_q;
                        grant_q   <= '0;
                        turn_q    <= TURN_W'(TURNAROUND);
                        state_q   <= ST_TURN;
                    end else if (hold_q != HOLD_W'(MAX_HOLD)) begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                ST_TURN: begin
                    if (turn_q == TURN_W'(1)) begin
                        turn_q  <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        turn_q <= turn_q - TURN_W'(1);
                    end
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end
`else
    assign revoked_o = '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            turn_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req_i) begin
                        grant_q <= grant_d;
                        owner_q <= sel_d;
                        ptr_q   <= sel_d;
                        busy_q  <= 1'b1;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!req_i[owner_q]) begin
                        grant_q <= '0;
                        turn_q  <= TURN_W'(TURNAROUND);
                        state_q <= ST_TURN;
                    end
                end
                ST_TURN: begin
                    if (turn_q == TURN_W'(1)) begin
                        turn_q  <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        turn_q <= turn_q - TURN_W'(1);
                    end
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end
`endif

    // Gating on the registered grant keeps uio_oe low in IDLE/TURN regardless of owner_q.
    assign uio_out_o = (|grant_q) ? req_out_i[{owner_q, 3'b000} +: 8] : 8'h00;
    assign uio_oe_o  = (|grant_q) ? req_oe_i[{owner_q, 3'b000} +: 8]  : 8'h00;

    assign grant_o = grant_q;
    assign owner_o = owner_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed self-checking bench for uio_bus_arbiter (NUM_REQ=4, TURNAROUND=1, MAX_HOLD=16).
module tb_uio_bus_arbiter;
    localparam int NREQ = 4;
    localparam int TURN = 1;
    localparam int HOLD = 16;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [NREQ-1:0]  req_i;
    logic [NREQ*8-1:0] req_out_i;
    logic [NREQ*8-1:0] req_oe_i;
    logic [NREQ-1:0]  grant_o;
    logic [NREQ-1:0]  revoked_o;
    logic [1:0]       owner_o;
    logic             busy_o;
    logic [7:0]       uio_out_o;
    logic [7:0]       uio_oe_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_oe [4] = '{8'hFF, 8'h0F, 8'hFF, 8'hF0};

    uio_bus_arbiter #(
        .NUM_REQ    (NREQ),
        .TURNAROUND (TURN),
        .MAX_HOLD   (HOLD)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .req_out_i (req_out_i),
        .req_oe_i  (req_oe_i),
        .grant_o   (grant_o),
        .revoked_o (revoked_o),
        .owner_o   (owner_o),
        .busy_o    (busy_o),
        .uio_out_o (uio_out_o),
        .uio_oe_o  (uio_oe_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        req_i = '0;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        int gap;
        int viol;
        int bad;
        bit seen;

        req_out_i = {8'h33, 8'h22, 8'h11, 8'hA5};
        req_oe_i  = {8'hF0, 8'hFF, 8'h0F, 8'hFF};

        // Reset state and single-requester grant latency
        do_reset();
        check_val("rst_grant", grant_o, 0);
        check_val("rst_revoked", revoked_o, 0);
        check_val("rst_busy", busy_o, 0);
        check_val("rst_uio_out", uio_out_o, 0);
        check_val("rst_uio_oe", uio_oe_o, 0);
        check_val("rst_owner", owner_o, 0);
        req_i = 4'b0001;
        #2;
        check_val("pre_edge_grant", grant_o, 0);
        tick();
        check_val("req0_grant", grant_o, 4'b0001);
        check_val("req0_uio_out", uio_out_o, 8'hA5);
        check_val("req0_uio_oe", uio_oe_o, 8'hFF);
        check_val("req0_busy", busy_o, 1);
        check_val("req0_owner", owner_o, 0);
        req_i = 4'b0000;
        tick();
        check_val("rel_grant", grant_o, 0);
        check_val("rel_oe", uio_oe_o, 0);
        check_val("rel_busy_turn", busy_o, 1);
        tick();
        check_val("idle_busy", busy_o, 0);
        check_val("idle_owner_hold", owner_o, 0);

        // Round-robin with all four requesting, each releasing after 3 cycles
        do_reset();
        req_i = 4'hF;
        viol = 0;
        for (int r = 0; r < 5; r++) begin
            gap  = 0;
            seen = 1'b0;
            for (int w = 0; w < 8 && !seen; w++) begin
                tick();
                if (!$onehot0(grant_o)) viol++;
                if (grant_o != 0) seen = 1'b1;
                else if (uio_oe_o == 0) gap++;
            end
            check_val("rr_grant", grant_o, 32'(1 << (r % 4)));
            check_val("rr_oe", uio_oe_o, exp_oe[r % 4]);
            if (r > 0) check_val("rr_gap", gap, TURN + 1);
            req_i = 4'hF;
            tick();
            tick();
            req_i[r % 4] = 1'b0;
        end
        check_val("rr_onehot", viol, 0);

        // Owner 2 releases with requester 1 pending
        do_reset();
        req_i = 4'b0100;
        tick();
        check_val("o2_grant", grant_o, 4'b0100);
        req_i = 4'b0110;
        tick();
        check_val("o2_keep", grant_o, 4'b0100);
        req_i = 4'b0010;
        tick();
        check_val("o2_drop_grant", grant_o, 0);
        check_val("o2_drop_oe", uio_oe_o, 0);
        tick();
        check_val("o2_gap_grant", grant_o, 0);
        tick();
        check_val("o1_grant", grant_o, 4'b0010);
        check_val("o1_uio_out", uio_out_o, 8'h11);
        check_val("o1_uio_oe", uio_oe_o, 8'h0F);

        // Reset asserted mid-grant
        do_reset();
        req_i = 4'b0100;
        tick();
        check_val("mid_grant", grant_o, 4'b0100);
        check_val("mid_oe", uio_oe_o, 8'hFF);
        rst_i = 1'b1;
        req_i = 4'b0101;
        tick();
        check_val("mid_rst_grant", grant_o, 0);
        check_val("mid_rst_oe", uio_oe_o, 0);
        check_val("mid_rst_busy", busy_o, 0);
        rst_i = 1'b0;
        tick();
        check_val("post_rst_grant", grant_o, 4'b0001);

        // Long hold by requester 0 with requester 3 raised on cycle 2
        do_reset();
        req_i = 4'b0001;
        tick();
        check_val("hold_grant1", grant_o, 4'b0001);
        tick();
        req_i = 4'b1001;
        for (int c = 0; c < 14; c++) tick();
        check_val("hold_cyc16_grant", grant_o, 4'b0001);
        check_val("hold_cyc16_rev", revoked_o, 0);
`ifdef UIO_ARB_TIMEOUT_EN
        tick();
        check_val("revoke_grant", grant_o, 0);
        check_val("revoke_pulse", revoked_o, 4'b0001);
        check_val("revoke_busy", busy_o, 1);
        tick();
        check_val("revoke_once", revoked_o, 0);
        tick();
        check_val("after_revoke_grant", grant_o, 4'b1000);
        req_i = 4'b0001;
        tick();
        tick();
        tick();
        check_val("regrant0", grant_o, 4'b0001);
`else
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (grant_o != 4'b0001 || revoked_o != 0) bad++;
        end
        check_val("no_timeout_hold", bad, 0);
        req_i = 4'b0001;
`endif
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (grant_o != 4'b0001 || revoked_o != 0) bad++;
        end
        check_val("alone_hold", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
